// File: rtl/grid_tile_scheduler.sv
// Grid tile scheduler: snapshots an occupancy map on start and walks the grid in
// row-major order, issuing one draw request per occupied cell to the tile drawer.
module grid_tile_scheduler #(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 6,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [GRID_W*GRID_H-1:0] occupancy,
    input  logic                     tile_done,
    output logic                     draw_req,
    output logic [3:0]               grid_x,
    output logic [3:0]               grid_y,
    output logic                     busy,
    output logic                     frame_done,
    output logic [5:0]               tiles_drawn,
    output logic                     timeout_err
);

    localparam int N  = GRID_W * GRID_H;
    localparam int IW = $clog2(N);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [5:0] TILE_MAX = 6'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REQ,
        S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_snap, w_snap_nxt;
    logic [3:0]    r_x, r_y, w_x_nxt, w_y_nxt;
    logic [CW-1:0] r_wait, w_wait_nxt;
    logic [5:0]    r_tiles, w_tiles_nxt;
    logic          r_err, w_err_nxt;
    logic          r_req, w_req_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_fdone, w_fdone_nxt;

    logic [IW-1:0] w_idx;
    logic          w_cell_occ;
    logic          w_last_x;
    logic          w_last_cell;
    logic          w_timeout;
    logic [3:0]    w_adv_x, w_adv_y;

    assign w_idx       = IW'(r_y) * IW'(GRID_W) + IW'(r_x);
    assign w_cell_occ  = r_snap[w_idx];
    assign w_last_x    = (r_x == 4'(GRID_W - 1));
    assign w_last_cell = w_last_x && (r_y == 4'(GRID_H - 1));
    // Advancing past the final cell wraps the coordinates back to the origin.
    assign w_adv_x     = w_last_x ? 4'd0 : r_x + 4'd1;
    assign w_adv_y     = w_last_cell ? 4'd0 : (w_last_x ? r_y + 4'd1 : r_y);
    assign w_timeout   = (TIMEOUT != 0) && (r_wait == CW'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every next value is defaulted first so no branch can infer a latch.
        w_state_nxt = r_state;
        w_snap_nxt  = r_snap;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_wait_nxt  = r_wait;
        w_tiles_nxt = r_tiles;
        w_err_nxt   = r_err;
        w_req_nxt   = r_req;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_snap_nxt  = occupancy;
                    w_x_nxt     = 4'd0;
                    w_y_nxt     = 4'd0;
                    w_tiles_nxt = 6'd0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_cell_occ) begin
                    w_req_nxt   = 1'b1;
                    w_wait_nxt  = '0;
                    w_state_nxt = S_REQ;
                end else begin
                    w_x_nxt     = w_adv_x;
                    w_y_nxt     = w_adv_y;
                    w_state_nxt = w_last_cell ? S_DONE : S_SCAN;
                end
            end
            S_REQ: begin
                // A completion in the same cycle as the timeout still counts.
                if (tile_done || w_timeout) begin
                    w_req_nxt   = 1'b0;
                    w_x_nxt     = w_adv_x;
                    w_y_nxt     = w_adv_y;
                    w_state_nxt = w_last_cell ? S_DONE : S_SCAN;
                    if (tile_done) begin
                        w_tiles_nxt = (r_tiles == TILE_MAX) ? r_tiles : r_tiles + 6'd1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_wait_nxt = r_wait + CW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_fdone_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_snap  <= '0;
            r_x     <= 4'd0;
            r_y     <= 4'd0;
            r_wait  <= '0;
            r_tiles <= 6'd0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_fdone <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            r_state <= w_state_nxt;
            r_snap  <= w_snap_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_wait  <= w_wait_nxt;
            r_tiles <= w_tiles_nxt;
            r_err   <= w_err_nxt;
            r_req   <= w_req_nxt;
            r_busy  <= w_busy_nxt;
            r_fdone <= w_fdone_nxt;
        end
    end

    assign draw_req    = r_req;
    assign grid_x      = r_x;
    assign grid_y      = r_y;
    assign busy        = r_busy;
    assign frame_done  = r_fdone;
    assign tiles_drawn = r_tiles;
    assign timeout_err = r_err;

endmodule
